prog_fetch_responder: RTL and testbench



---
 rtl/prog_fetch_pkg.sv | 39 +++
 rtl/prog_fetch_fifo.sv | 69 ++++++
 rtl/prog_fetch_responder.sv | 116 +++++++++++
 tb/tb_prog_fetch_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_fetch_pkg.sv
// Shared widths, response-entry layout and the synthetic program-data generator.
// Defining PROG_FETCH_PARITY_EN adds a parity bit to each response entry.
package prog_fetch_pkg;

  localparam int PROG_ADR_W = 13;
  localparam int PROG_DAT_W = 14;

  typedef struct packed {
    logic [PROG_ADR_W-1:0] adr;
    logic [PROG_DAT_W-1:0] dat;
`ifdef PROG_FETCH_PARITY_EN
    logic                  par;
`endif
  } rsp_entry_t;

  localparam int RSP_ENTRY_W = $bits(rsp_entry_t);

  // Program word is the address with its parity appended, scrambled by the seed.
  function automatic logic [PROG_DAT_W-1:0] gen_prog_dat(
    input logic [PROG_ADR_W-1:0] adr,
    input logic [PROG_DAT_W-1:0] seed
  );
    return {adr, ^adr} ^ seed;
  endfunction

  function automatic rsp_entry_t make_entry(
    input logic [PROG_ADR_W-1:0] adr,
    input logic [PROG_DAT_W-1:0] seed
  );
    rsp_entry_t e;
    e.adr = adr;
    e.dat = gen_prog_dat(adr, seed);
`ifdef PROG_FETCH_PARITY_EN
    e.par = ~^e.dat;
`endif
    return e;
  endfunction

endpackage

// File: rtl/prog_fetch_fifo.sv
// Show-ahead FIFO with occupancy count; the head output holds the last popped
// entry while empty so downstream data lines stay stable.
module prog_fetch_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_pop;
  logic             full;

  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    full     = (cnt_q == CNT_W'(DEPTH));
    wr_ptr_d = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    hold_d   = do_pop ? mem[rd_ptr_q] : hold_q;
    case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign valid     = (cnt_q != '0);
  assign count     = cnt_q;
  assign head_data = valid ? mem[rd_ptr_q] : hold_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/prog_fetch_responder.sv
// Program-fetch responder: fixed-latency read pipeline into a credit-guarded
// show-ahead response FIFO. Defining PROG_FETCH_PARITY_EN adds the rsp_par output.
module prog_fetch_responder
  import prog_fetch_pkg::*;
#(
  parameter int              READ_LATENCY = 2,
  parameter int              FIFO_DEPTH   = 4,
  parameter logic [13:0]     DAT_SEED     = 14'h2A5C
) (
  input  logic        clk,
  input  logic        pon_rst_i,
  input  logic        fetch_enable,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [12:0] req_adr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [13:0] rsp_dat,
  output logic [12:0] rsp_adr,
  output logic [15:0] served_cnt,
`ifdef PROG_FETCH_PARITY_EN
  output logic        rsp_par,
`endif
  output logic        idle
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int USE_W = CNT_W + 1;

  logic                   run_q, run_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [PROG_ADR_W-1:0]  adr_q [READ_LATENCY];
  logic [PROG_ADR_W-1:0]  adr_d [READ_LATENCY];
  logic [15:0]            served_q, served_d;

  logic [3:0]             inflight;
  logic [USE_W-1:0]       used;
  logic [CNT_W-1:0]       fifo_count;
  logic                   accept;
  logic                   push;
  logic                   pop;
  rsp_entry_t             push_entry;
  rsp_entry_t             head_entry;
  logic [RSP_ENTRY_W-1:0] head_bits;

  // Credits count everything already committed; a same-cycle pop is not credited.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + 4'(vld_q[i]);
    end
    used      = USE_W'(fifo_count) + USE_W'(inflight);
    req_ready = run_q && fetch_enable && (used < USE_W'(FIFO_DEPTH));
    accept    = req_valid && req_ready;
  end

  // The pipeline never stalls: the credit check already reserved a FIFO slot.
  always_comb begin
    vld_d[0] = accept;
    adr_d[0] = req_adr;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      adr_d[i] = adr_q[i-1];
    end
  end

  always_comb begin
    run_d      = 1'b1;
    push       = vld_q[READ_LATENCY-1];
    push_entry = make_entry(adr_q[READ_LATENCY-1], DAT_SEED);
    pop        = rsp_valid && rsp_ready;
    served_d   = (pop && (served_q != 16'hFFFF)) ? served_q + 16'd1 : served_q;
  end

  always_ff @(posedge clk or posedge pon_rst_i) begin
    if (pon_rst_i) begin
      run_q    <= 1'b0;
      vld_q    <= '0;
      served_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        adr_q[i] <= '0;
      end
    end else begin
      run_q    <= run_d;
      vld_q    <= vld_d;
      served_q <= served_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        adr_q[i] <= adr_d[i];
      end
    end
  end

  prog_fetch_fifo #(
    .WIDTH (RSP_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (pon_rst_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_bits),
    .valid     (rsp_valid),
    .count     (fifo_count)
  );

  assign head_entry = rsp_entry_t'(head_bits);
  assign rsp_dat    = head_entry.dat;
  assign rsp_adr    = head_entry.adr;
`ifdef PROG_FETCH_PARITY_EN
  assign rsp_par    = head_entry.par;
`endif
  assign served_cnt = served_q;
  assign idle       = (inflight == '0) && (fifo_count == '0);

endmodule

// File: tb/tb_prog_fetch_responder.sv
// Self-checking bench for prog_fetch_responder against a queue-based reference model.
module tb_prog_fetch_responder;

  logic        clk = 1'b0;
  logic        pon_rst_i;
  logic        fetch_enable;
  logic        req_valid;
  logic        req_ready;
  logic [12:0] req_adr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [13:0] rsp_dat;
  logic [12:0] rsp_adr;
  logic [15:0] served_cnt;
  logic        idle;
`ifdef PROG_FETCH_PARITY_EN
  logic        rsp_par;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [12:0] adr;
    logic [13:0] dat;
    logic        par;
    int          cyc;
  } obs_t;

  logic [12:0] exp_q[$];
  obs_t        got_q[$];
  int          cyc   = 0;
  int          n_acc = 0;
  int          n_rsp = 0;

  prog_fetch_responder dut (
    .clk          (clk),
    .pon_rst_i    (pon_rst_i),
    .fetch_enable (fetch_enable),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_adr      (req_adr),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_dat      (rsp_dat),
    .rsp_adr      (rsp_adr),
    .served_cnt   (served_cnt),
`ifdef PROG_FETCH_PARITY_EN
    .rsp_par      (rsp_par),
`endif
    .idle         (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Reference data: address doubled plus its ones-count parity, XOR the seed.
  function automatic logic [13:0] model_dat(input logic [12:0] a);
    int ones = 0;
    int v;
    for (int i = 0; i < 13; i++) ones += int'(a[i]);
    v = (int'(a) * 2 + (ones % 2)) ^ 'h2A5C;
    return v[13:0];
  endfunction

  function automatic logic model_par(input logic [13:0] d);
    int ones = 0;
    for (int i = 0; i < 14; i++) ones += int'(d[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // One clock of stimulus; records accepted requests and observed responses.
  task automatic drive(input logic v, input logic [12:0] a, input logic rr);
    obs_t r;
    req_valid = v;
    req_adr   = a;
    rsp_ready = rr;
    #1;
    if (v && req_ready) begin
      exp_q.push_back(a);
      n_acc++;
    end
    if (rsp_valid && rr) begin
      r.adr = rsp_adr;
      r.dat = rsp_dat;
`ifdef PROG_FETCH_PARITY_EN
      r.par = rsp_par;
`else
      r.par = 1'b0;
`endif
      r.cyc = cyc;
      got_q.push_back(r);
      n_rsp++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    pon_rst_i = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pon_rst_i = 1'b0;
    exp_q.delete();
    got_q.delete();
    n_acc = 0;
    n_rsp = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pon_rst_i    = 1'b1;
    fetch_enable = 1'b1;
    req_valid    = 1'b0;
    req_adr      = '0;
    rsp_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (served_cnt !== 16'h0) begin bad++; $display("FAIL reset_served: got %h want 0", served_cnt); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", idle); end
    total++; if (rsp_dat !== 14'h0) begin bad++; $display("FAIL reset_rsp_dat: got %h want 0", rsp_dat); end
    total++; if (rsp_adr !== 13'h0) begin bad++; $display("FAIL reset_rsp_adr: got %h want 0", rsp_adr); end
`ifdef PROG_FETCH_PARITY_EN
    total++; if (rsp_par !== 1'b0) begin bad++; $display("FAIL reset_rsp_par: got %b want 0", rsp_par); end
`endif
    pon_rst_i = 1'b0;
    @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL release_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_single();
    logic [13:0] want;
    exp_q.delete(); got_q.delete();
    want = model_dat(13'h0000);
    drive(1'b1, 13'h0000, 1'b0);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early1: got %b want 0", rsp_valid); end
    drive(1'b0, 13'h0000, 1'b0);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early2: got %b want 0", rsp_valid); end
    drive(1'b0, 13'h0000, 1'b0);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_latency: got %b want 1", rsp_valid); end
    total++; if (rsp_dat !== 14'h2A5C) begin bad++; $display("FAIL single_dat: got %h want 2a5c", rsp_dat); end
    total++; if (rsp_dat !== want) begin bad++; $display("FAIL single_dat_model: got %h want %h", rsp_dat, want); end
    total++; if (rsp_adr !== 13'h0) begin bad++; $display("FAIL single_adr: got %h want 0", rsp_adr); end
`ifdef PROG_FETCH_PARITY_EN
    total++; if (rsp_par !== model_par(want)) begin bad++; $display("FAIL single_par: got %b want %b", rsp_par, model_par(want)); end
`endif
    drive(1'b0, 13'h0000, 1'b1);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_popped: got %b want 0", rsp_valid); end
    total++; if (rsp_dat !== want) begin bad++; $display("FAIL single_hold_dat: got %h want %h", rsp_dat, want); end
    total++; if (served_cnt !== 16'd1) begin bad++; $display("FAIL single_served: got %0d want 1", served_cnt); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_back_to_back();
    exp_q.delete(); got_q.delete();
    drive(1'b1, 13'h0001, 1'b1);
    drive(1'b1, 13'h1FFF, 1'b1);
    repeat (6) drive(1'b0, 13'h0000, 1'b1);
    total++; if (got_q.size() !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      total++; if (got_q[0].dat !== 14'h2A5F) begin bad++; $display("FAIL b2b_dat0: got %h want 2a5f", got_q[0].dat); end
      total++; if (got_q[1].dat !== 14'h15A3) begin bad++; $display("FAIL b2b_dat1: got %h want 15a3", got_q[1].dat); end
      total++; if (got_q[0].adr !== 13'h0001) begin bad++; $display("FAIL b2b_adr0: got %h want 0001", got_q[0].adr); end
      total++; if (got_q[1].adr !== 13'h1FFF) begin bad++; $display("FAIL b2b_adr1: got %h want 1fff", got_q[1].adr); end
      total++; if (got_q[1].cyc !== got_q[0].cyc + 1) begin bad++; $display("FAIL b2b_consecutive: got gap %0d want 1", got_q[1].cyc - got_q[0].cyc); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (8) drive(1'b1, 13'($urandom), 1'b0);
    total++; if (n_acc !== 4) begin bad++; $display("FAIL bp_accepted: got %0d want 4", n_acc); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready: got %b want 0", req_ready); end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); end
    repeat (8) drive(1'b0, 13'h0000, 1'b1);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL bp_drained: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i].adr !== exp_q[i]) begin bad++; $display("FAIL bp_adr[%0d]: got %h want %h", i, got_q[i].adr, exp_q[i]); end
      total++; if (got_q[i].dat !== model_dat(exp_q[i])) begin bad++; $display("FAIL bp_dat[%0d]: got %h want %h", i, got_q[i].dat, model_dat(exp_q[i])); end
    end
    total++; if (served_cnt !== 16'd4) begin bad++; $display("FAIL bp_served: got %0d want 4", served_cnt); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL bp_idle: got %b want 1", idle); end
  endtask

  task automatic test_fetch_disable();
    exp_q.delete(); got_q.delete();
    drive(1'b1, 13'h0ABC, 1'b1);
    drive(1'b1, 13'h1234, 1'b1);
    fetch_enable = 1'b0;
    req_valid    = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL fe_req_ready: got %b want 0", req_ready); end
    repeat (6) drive(1'b1, 13'($urandom), 1'b1);
    total++; if (exp_q.size() !== 2) begin bad++; $display("FAIL fe_accepted: got %0d want 2", exp_q.size()); end
    total++; if (got_q.size() !== 2) begin bad++; $display("FAIL fe_delivered: got %0d want 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i].dat !== model_dat(exp_q[i])) begin bad++; $display("FAIL fe_dat[%0d]: got %h want %h", i, got_q[i].dat, model_dat(exp_q[i])); end
    end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL fe_idle: got %b want 1", idle); end
    fetch_enable = 1'b1;
  endtask

  task automatic test_reset_full();
    do_reset();
    repeat (8) drive(1'b1, 13'($urandom), 1'b0);
    drive(1'b0, 13'h0000, 1'b1);
    repeat (6) drive(1'b1, 13'($urandom), 1'b0);
    total++; if (served_cnt !== 16'd1) begin bad++; $display("FAIL rf_pre_served: got %0d want 1", served_cnt); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rf_pre_full: got %b want 0", req_ready); end
    pon_rst_i = 1'b1;
    #2;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rf_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (served_cnt !== 16'd0) begin bad++; $display("FAIL rf_served: got %0d want 0", served_cnt); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rf_idle: got %b want 1", idle); end
    @(posedge clk);
    #1;
    pon_rst_i = 1'b0;
    exp_q.delete(); got_q.delete();
    n_acc = 0; n_rsp = 0;
    repeat (10) drive(1'b0, 13'h0000, 1'b1);
    total++; if (got_q.size() !== 0) begin bad++; $display("FAIL rf_stale: got %0d responses want 0", got_q.size()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      fetch_enable = ($urandom_range(0, 7) != 0);
      drive(($urandom_range(0, 3) != 0), 13'($urandom), ($urandom_range(0, 2) != 0));
      total++;
      if (req_ready !== (fetch_enable && (n_acc - n_rsp) < 4)) begin
        bad++; $display("FAIL rnd_credit@%0d: got %b want %b", k, req_ready, (fetch_enable && (n_acc - n_rsp) < 4));
      end
      total++;
      if (idle !== (n_acc == n_rsp)) begin
        bad++; $display("FAIL rnd_idle@%0d: got %b want %b", k, idle, (n_acc == n_rsp));
      end
    end
    fetch_enable = 1'b1;
    repeat (12) drive(1'b0, 13'h0000, 1'b1);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i].adr !== exp_q[i]) begin bad++; $display("FAIL rnd_adr[%0d]: got %h want %h", i, got_q[i].adr, exp_q[i]); end
      total++; if (got_q[i].dat !== model_dat(exp_q[i])) begin bad++; $display("FAIL rnd_dat[%0d]: got %h want %h", i, got_q[i].dat, model_dat(exp_q[i])); end
`ifdef PROG_FETCH_PARITY_EN
      total++; if (got_q[i].par !== model_par(model_dat(exp_q[i]))) begin bad++; $display("FAIL rnd_par[%0d]: got %b want %b", i, got_q[i].par, model_par(model_dat(exp_q[i]))); end
`endif
    end
    total++; if (served_cnt !== 16'(exp_q.size())) begin bad++; $display("FAIL rnd_served: got %0d want %0d", served_cnt, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_fetch_disable();
    test_reset_full();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
